acc_drain: RTL and testbench
============================

# acc_drain

Read-side companion to `accumulator_bank`. The write side fills the bank with partial sums. This block walks a programmed number of bank rows and reads each one through the bank's combinational read port. For every row it:
- requantizes each 32-bit column sum to int8 (scale, round, shift, saturate);
- streams the packed row out on a valid/ready interface;
- optionally zeroes the row behind it, so the bank is ready for the next tile.

It sits between the accumulator bank and the output/activation buffer.

## Interface
Parameters:
- `ARRAY_COL`, 16, columns per bank row
- `ACC_WIDTH`, 32, signed accumulator width per column
- `ADDR_W`, 4, bank row address width (bank depth = 2^ADDR_W)
- `OUT_W`, 8, signed output width per column

Ports (one synchronous clock domain; reset is synchronous and active-high):
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  one-cycle request to begin a drain
- `row_count`  in  ADDR_W+1  rows to drain, 0..2^ADDR_W
- `clear_en`  in  1  zero each row after reading it
- `scale`  in  16  unsigned multiplier
- `shift`  in  5  right-shift amount, 0..31
- `busy`  out  1  high from start acceptance until done
- `done`  out  1  one-cycle pulse at drain completion
- `acc_addr`  out  ADDR_W  bank row address
- `acc_wr_en`  out  1  bank write enable (clear only)
- `acc_mode`  out  1  bank acc_mode; constant 0 (overwrite)
- `acc_wdata`  out  ARRAY_COL*ACC_WIDTH  bank write data; constant 0
- `acc_rdata`  in  ARRAY_COL*ACC_WIDTH  bank out_acc_vec (async read)
- `m_valid`  out  1  output row valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  ARRAY_COL*OUT_W  packed int8 row; column c at [c*OUT_W +: OUT_W]
- `m_last`  out  1  marks the final row of the drain

## Operation
- The FSM has four states: IDLE, READ, QUANT, OUT.
- **IDLE**
  - `start` is sampled here only and latches `row_count`, `clear_en`, `scale` and `shift`.
  - `row_count` = 0: no bank access. `done` pulses the next cycle and the FSM stays in IDLE.
  - `row_count` > 2^ADDR_W: clamped to 2^ADDR_W.
  - Otherwise go to READ with the row counter = 0.
- **READ** (one cycle)
  - `acc_addr` = row counter.
  - `acc_rdata` is registered into the capture register at the end of the cycle.
  - If `clear_en` is latched, `acc_wr_en` = 1 this cycle. The clear lands on the same edge as the capture, so the captured data is the pre-clear value.
  - Next state: QUANT.
- **QUANT** (one cycle): per column, compute the result below and register it into `m_data`. Next state: OUT.
  - p = signed(acc) × unsigned(scale), a 48-bit signed product.
  - If shift > 0: r = (p + (1 << (shift−1))) >>> shift, arithmetic shift, round-half-up.
  - If shift = 0: r = p.
  - Saturate r to [−128, 127].
- **OUT**
  - `m_valid` = 1. `m_last` = 1 if the row counter = latched count − 1.
  - On `m_valid && m_ready`:
    - Last row: `done` pulses, `busy` drops and the FSM returns to IDLE.
    - Otherwise: increment the row counter and go to READ.
- `busy` = (state != IDLE).
- `start` while busy is ignored. Changes to `scale`, `shift` or `clear_en` while busy have no effect.
- The row counter never wraps: the drain ends at the last row.

## Timing
- Reset values: all outputs 0 (`busy`, `done`, `acc_addr`, `acc_wr_en`, `acc_mode`, `acc_wdata`, `m_valid`, `m_data`, `m_last`). The FSM and row counter reset to IDLE/0.
- `start` sampled at edge T: READ for row 0 during cycle T+1, QUANT during T+2, `m_valid` high from T+3.
- Steady state is at best one row per 3 cycles (READ, QUANT, OUT with immediate `m_ready`).
- Handshake:
  - `m_data` and `m_last` are held stable while `m_valid && !m_ready`.
  - `m_valid` never drops without a transfer.
  - `m_ready` may be high before `m_valid`.
- `done` is asserted in the cycle after the final transfer edge, coincident with `busy` = 0. The FSM can accept a new `start` in that same cycle.
- `acc_wr_en` is high only in READ cycles with `clear_en` latched. It is never high in IDLE, QUANT or OUT.
- `rst` mid-drain takes effect at the next edge:
  - All outputs go to their reset values.
  - No `done` pulse.
  - Rows not yet cleared remain in the bank.

## Test plan
- Bank rows 0..2 preloaded with 100, 150 and −200 in every column; `row_count`=3, `scale`=1, `shift`=0, `m_ready`=1. Required: three transfers of 100, 127 and −128 in every column; `m_last` only on the third; `done` one cycle later; first `m_valid` 3 cycles after `start`.
- Row 0 = 50 and row 1 = −50 in all columns; `scale`=3, `shift`=2. Required: 38 (150/4 rounded) and −37 ((−150+2)>>>2).
- Backpressure: `m_ready` held low 5 cycles on row 1. Required: `m_valid` stays high, `m_data` stable, no further bank reads, and the transfer completes on the first `m_ready` cycle.
- `clear_en`=1, `row_count`=2, rows 0/1 = 99. Required: output 99 for both rows. Afterwards the bank reads 0 at rows 0/1 and row 2 is untouched.
- Edge cases:
  - `start` with `row_count`=0: `done` pulse next cycle, no `m_valid` and no `acc_wr_en`.
  - `start` pulsed while busy: ignored, so only one `done`.
- `rst` asserted in the QUANT cycle of row 1: the next cycle has all outputs 0 and the FSM in IDLE. A fresh `start` then drains normally from row 0.

Source files
------------

// File: rtl/acc_drain_if.sv
// Output row stream from the drain: one packed int8 row per valid/ready transfer.
interface acc_drain_if #(
    parameter int unsigned ARRAY_COL = 16,
    parameter int unsigned OUT_W     = 8
);
    logic                       m_valid;
    logic                       m_ready;
    logic [ARRAY_COL*OUT_W-1:0] m_data;
    logic                       m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/acc_drain.sv
// Drains accumulator bank rows: read, requantize each column to int8, stream out,
// and optionally zero each row behind the read.
module acc_drain #(
    parameter int unsigned ARRAY_COL = 16,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned OUT_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_W:0]                row_count,
    input  logic                           clear_en,
    input  logic [15:0]                    scale,
    input  logic [4:0]                     shift,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_W-1:0]              acc_addr,
    output logic                           acc_wr_en,
    output logic                           acc_mode,
    output logic [ARRAY_COL*ACC_WIDTH-1:0] acc_wdata,
    input  logic [ARRAY_COL*ACC_WIDTH-1:0] acc_rdata,
    acc_drain_if.master                    m
);

    // Product width: signed accumulator times zero-extended 16-bit scale, with headroom
    // so the rounding add cannot overflow.
    localparam int unsigned PW = ACC_WIDTH + 17;
    localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(1 << (OUT_W - 1)));
    localparam logic [ADDR_W:0] MAX_ROWS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_ROW  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRead, StQuant, StOut} state_e;

    state_e                         state_q, state_d;
    logic [ADDR_W-1:0]              row_q, row_d;
    logic [ADDR_W:0]                count_q, count_d;
    logic                           clear_q, clear_d;
    logic [15:0]                    scale_q, scale_d;
    logic [4:0]                     shift_q, shift_d;
    logic [ARRAY_COL*ACC_WIDTH-1:0] cap_q, cap_d;
    logic [ARRAY_COL*OUT_W-1:0]     data_q, data_d;
    logic                           done_q, done_d;
    logic [ARRAY_COL*OUT_W-1:0]     quant;
    logic                           last_row;

    // Scale, round half-up, arithmetic shift, then saturate one column.
    function automatic logic [OUT_W-1:0] requant(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [15:0] scl,
                                                 input logic [4:0] sh);
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] rnd;
        logic signed [PW-1:0] res;
        logic [OUT_W-1:0]     out;
        prod = $signed({{17{acc[ACC_WIDTH-1]}}, acc}) * $signed({{(PW-16){1'b0}}, scl});
        rnd  = '0;
        if (sh != 5'd0) begin
            rnd = PW'(1) << (sh - 5'd1);
        end
        res = (prod + rnd) >>> sh;
        if (res > SAT_MAX) begin
            out = SAT_MAX[OUT_W-1:0];
        end else if (res < SAT_MIN) begin
            out = SAT_MIN[OUT_W-1:0];
        end else begin
            out = res[OUT_W-1:0];
        end
        return out;
    endfunction

    assign last_row = ({1'b0, row_q} == (count_q - ONE_ROW));

    // Requantize every column of the captured row.
    always_comb begin
        quant = '0;
        for (int c = 0; c < ARRAY_COL; c++) begin
            quant[c*OUT_W +: OUT_W] = requant(cap_q[c*ACC_WIDTH +: ACC_WIDTH], scale_q, shift_q);
        end
    end

    // Next-state logic and the bank clear strobe.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        count_d   = count_q;
        clear_d   = clear_q;
        scale_d   = scale_q;
        shift_d   = shift_q;
        cap_d     = cap_q;
        data_d    = data_q;
        done_d    = 1'b0;
        acc_wr_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clear_d = clear_en;
                    scale_d = scale;
                    shift_d = shift;
                    row_d   = '0;
                    if (row_count == '0) begin
                        count_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        count_d = (row_count > MAX_ROWS) ? MAX_ROWS : row_count;
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                // Clear and capture share an edge, so the capture holds the pre-clear value.
                cap_d     = acc_rdata;
                acc_wr_en = clear_q;
                state_d   = StQuant;
            end
            StQuant: begin
                data_d  = quant;
                state_d = StOut;
            end
            StOut: begin
                if (m.m_ready) begin
                    if (last_row) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        row_d   = row_q + ADDR_W'(1);
                        state_d = StRead;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            count_q <= '0;
            clear_q <= 1'b0;
            scale_q <= '0;
            shift_q <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            count_q <= count_d;
            clear_q <= clear_d;
            scale_q <= scale_d;
            shift_q <= shift_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign acc_addr  = row_q;
    assign acc_mode  = 1'b0;
    assign acc_wdata = '0;
    assign m.m_valid = (state_q == StOut);
    assign m.m_data  = data_q;
    assign m.m_last  = (state_q == StOut) && last_row;

endmodule

// File: tb/tb_acc_drain.sv
// Self-checking bench for acc_drain with a behavioural accumulator bank.
module tb_acc_drain;
    localparam int ARRAY_COL = 16;
    localparam int ACC_WIDTH = 32;
    localparam int ADDR_W    = 4;
    localparam int OUT_W     = 8;
    localparam int RW        = ARRAY_COL * ACC_WIDTH;
    localparam int DW        = ARRAY_COL * OUT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   row_count;
    logic              clear_en;
    logic [15:0]       scale;
    logic [4:0]        shift;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_wr_en;
    logic              acc_mode;
    logic [RW-1:0]     acc_wdata;
    logic [RW-1:0]     acc_rdata;

    acc_drain_if #(.ARRAY_COL(ARRAY_COL), .OUT_W(OUT_W)) m_if ();

    acc_drain #(
        .ARRAY_COL(ARRAY_COL),
        .ACC_WIDTH(ACC_WIDTH),
        .ADDR_W   (ADDR_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .row_count(row_count),
        .clear_en (clear_en),
        .scale    (scale),
        .shift    (shift),
        .busy     (busy),
        .done     (done),
        .acc_addr (acc_addr),
        .acc_wr_en(acc_wr_en),
        .acc_mode (acc_mode),
        .acc_wdata(acc_wdata),
        .acc_rdata(acc_rdata),
        .m        (m_if)
    );

    always #5 clk = ~clk;

    // Bank model: async read, sync write; the bench preloads through its own port.
    logic [RW-1:0]     bank [2**ADDR_W];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [RW-1:0]     pre_data;

    always @(posedge clk) begin
        if (pre_we) bank[pre_addr] <= pre_data;
        else if (acc_wr_en) bank[acc_addr] <= acc_wdata;
    end
    assign acc_rdata = bank[acc_addr];

    // Event counters sampled at the active edge.
    int wr_cnt = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int last_cnt = 0;
    always @(posedge clk) begin
        if (acc_wr_en) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (m_if.m_valid && m_if.m_ready) xfer_cnt <= xfer_cnt + 1;
        if (m_if.m_valid && m_if.m_ready && m_if.m_last) last_cnt <= last_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] row8(input int v);
        return {ARRAY_COL{v[7:0]}};
    endfunction

    function automatic logic [RW-1:0] row32(input int v);
        return {ARRAY_COL{v[31:0]}};
    endfunction

    task automatic preload(input int row, input int val);
        pre_we   = 1'b1;
        pre_addr = row[ADDR_W-1:0];
        pre_data = row32(val);
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!m_if.m_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " valid seen"}, m_if.m_valid, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " acc_addr"}, acc_addr, '0);
        check({tag, " acc_wr_en"}, acc_wr_en, 1'b0);
        check({tag, " acc_mode"}, acc_mode, 1'b0);
        check({tag, " acc_wdata"}, acc_wdata, '0);
        check({tag, " m_valid"}, m_if.m_valid, 1'b0);
        check({tag, " m_data"}, m_if.m_data, '0);
        check({tag, " m_last"}, m_if.m_last, 1'b0);
    endtask

    typedef struct {
        int v0, v1, v2;
        int cnt, scl, sh;
        bit clr;
        int e0, e1, e2;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input string tag);
        int vv[3];
        int ev[3];
        int lat;
        int got;
        int wr0;
        int exp_bank;
        vv = '{v.v0, v.v1, v.v2};
        ev = '{v.e0, v.e1, v.e2};
        for (int i = 0; i < 3; i++) preload(i, vv[i]);
        row_count    = v.cnt[ADDR_W:0];
        clear_en     = v.clr;
        scale        = v.scl[15:0];
        shift        = v.sh[4:0];
        m_if.m_ready = 1'b1;
        wr0          = wr_cnt;
        pulse_start();
        // Changing controls mid-drain must not affect the result.
        scale    = 16'hffff;
        shift    = 5'd0;
        clear_en = ~v.clr;
        check({tag, " busy after start"}, busy, 1'b1);
        lat = 1;
        while (!m_if.m_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " first valid latency"}, lat, 3);
        got = 0;
        for (int cyc = 0; cyc < 40 && got < v.cnt; cyc++) begin
            if (m_if.m_valid) begin
                check($sformatf("%s row%0d data", tag, got), m_if.m_data, row8(ev[got]));
                check($sformatf("%s row%0d last", tag, got), m_if.m_last, got == v.cnt - 1);
                got++;
                tick();
                if (got == v.cnt) begin
                    check({tag, " done pulse"}, done, 1'b1);
                    check({tag, " busy drop"}, busy, 1'b0);
                    tick();
                    check({tag, " done one cycle"}, done, 1'b0);
                end
            end else begin
                tick();
            end
        end
        check({tag, " rows"}, got, v.cnt);
        check({tag, " clear writes"}, wr_cnt - wr0, v.clr ? v.cnt : 0);
        for (int r = 0; r < 3; r++) begin
            exp_bank = (v.clr && r < v.cnt) ? 0 : vv[r];
            check($sformatf("%s bank row%0d", tag, r), bank[r], row32(exp_bank));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int x0;
        int w0;
        int l0;
        int n;
        logic [RW-1:0] colrow;
        logic [DW-1:0] colexp;

        rst          = 1'b1;
        start        = 1'b0;
        row_count    = '0;
        clear_en     = 1'b0;
        scale        = '0;
        shift        = '0;
        m_if.m_ready = 1'b0;
        pre_we       = 1'b0;
        pre_addr     = '0;
        pre_data     = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        for (int r = 0; r < 2**ADDR_W; r++) preload(r, 0);
        rst = 1'b0;
        tick();

        //          v0    v1     v2  cnt scl    sh clr e0   e1    e2
        vecs[0] = '{100,  150,  -200, 3, 1,     0, 0, 100, 127, -128};
        vecs[1] = '{50,   -50,  0,    2, 3,     2, 0, 38,  -37, 0};
        vecs[2] = '{99,   99,   7,    2, 1,     0, 1, 99,  99,  0};
        vecs[3] = '{1000, -1000, 3,   2, 1,     3, 0, 125, -125, 0};
        vecs[4] = '{6,    -6,   10,   3, 1,     2, 0, 2,   -1,  3};
        vecs[5] = '{5,    -5,   0,    3, 65535, 16, 0, 5,  -5,  0};
        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Distinct value per column exposes column packing.
        colrow = '0;
        colexp = '0;
        for (int c = 0; c < ARRAY_COL; c++) begin
            n = c * 10 - 70;
            colrow[c*ACC_WIDTH +: ACC_WIDTH] = n[31:0];
            colexp[c*OUT_W +: OUT_W] = n[7:0];
        end
        pre_we = 1'b1; pre_addr = '0; pre_data = colrow; tick(); pre_we = 1'b0;
        row_count = 1; clear_en = 1'b0; scale = 1; shift = 0; m_if.m_ready = 1'b1;
        pulse_start();
        wait_valid("cols");
        check("cols data", m_if.m_data, colexp);
        check("cols last", m_if.m_last, 1'b1);
        tick();
        check("cols done", done, 1'b1);

        // Zero rows: done only, no bank or stream activity.
        w0 = wr_cnt; x0 = xfer_cnt;
        row_count = 0; clear_en = 1'b1;
        pulse_start();
        check("zero done", done, 1'b1);
        check("zero busy", busy, 1'b0);
        tick();
        check("zero done once", done, 1'b0);
        repeat (3) tick();
        check("zero xfers", xfer_cnt - x0, 0);
        check("zero writes", wr_cnt - w0, 0);

        // Oversized count clamps to the bank depth.
        x0 = xfer_cnt; d0 = done_cnt; l0 = last_cnt;
        row_count = 5'd31; clear_en = 1'b0;
        pulse_start();
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            tick();
            n++;
        end
        check("clamp xfers", xfer_cnt - x0, 16);
        check("clamp last", last_cnt - l0, 1);

        // Start while busy is ignored, including a zero-count start.
        preload(0, 5); preload(1, 5);
        d0 = done_cnt; x0 = xfer_cnt;
        row_count = 2; scale = 1; shift = 0;
        pulse_start();
        row_count = 0;
        pulse_start();
        row_count = 2;
        tick();
        pulse_start();
        n = 0;
        while (done_cnt == d0 && n < 40) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("busy start dones", done_cnt - d0, 1);
        check("busy start xfers", xfer_cnt - x0, 2);

        // Backpressure on row 1.
        preload(0, 10); preload(1, 20); preload(2, 30);
        row_count = 3; clear_en = 1'b1; scale = 2; shift = 1; m_if.m_ready = 1'b1;
        pulse_start();
        wait_valid("bp row0");
        check("bp row0 data", m_if.m_data, row8(10));
        tick();
        m_if.m_ready = 1'b0;
        wait_valid("bp row1");
        w0 = wr_cnt;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp stall%0d valid", k), m_if.m_valid, 1'b1);
            check($sformatf("bp stall%0d data", k), m_if.m_data, row8(20));
            check($sformatf("bp stall%0d last", k), m_if.m_last, 1'b0);
            check($sformatf("bp stall%0d writes", k), wr_cnt - w0, 0);
            tick();
        end
        m_if.m_ready = 1'b1;
        check("bp held before ready", m_if.m_valid, 1'b1);
        tick();
        check("bp transfer on ready", m_if.m_valid, 1'b0);
        wait_valid("bp row2");
        check("bp row2 data", m_if.m_data, row8(30));
        check("bp row2 last", m_if.m_last, 1'b1);
        tick();
        check("bp done", done, 1'b1);

        // Reset during QUANT of row 1.
        preload(0, 11); preload(1, 22); preload(2, 33);
        row_count = 3; clear_en = 1'b1; scale = 1; shift = 0; m_if.m_ready = 1'b1;
        pulse_start();
        wait_valid("rst row0");
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        check("midrst no done", done, 1'b0);
        check("midrst row1 cleared", bank[1], row32(0));
        check("midrst row2 kept", bank[2], row32(33));
        run_vec(vecs[0], "post rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
